// File: rtl/reg_set_pkg.sv
// ============================================================================
// Module : reg_set_pkg
// Brief  : Shared constants and depth derivation for the 2R1W register set.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_set_pkg;

    localparam int unsigned RS_N_DEFAULT = 8;
    localparam int unsigned RS_W_DEFAULT = 3;

    // Entry count for a given address width.
    function automatic int unsigned rs_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    // Read result at the default width. The read port declares the same
    // layout sized by its own N, so non-default widths work too.
    typedef struct packed {
        logic [RS_N_DEFAULT-1:0] data;
        logic                    vld;
    } rd_result_t;

endpackage

`default_nettype wire

// File: rtl/reg_set_rd_port.sv
// ============================================================================
// Module : reg_set_rd_port
// Brief  : One registered read port: entry select, optional write forwarding
//          (REG_SET_BYPASS_EN), clear/reset, output register.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_set_rd_port
    import reg_set_pkg::*;
#(
    parameter int unsigned N = RS_N_DEFAULT,
    parameter int unsigned w = RS_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic [w-1:0]           rd_addr,
    input  logic [N-1:0]           mem [rs_depth(w)],
    input  logic [rs_depth(w)-1:0] flags,
`ifdef REG_SET_BYPASS_EN
    input  logic                   wen,
    input  logic [w-1:0]           wr_addr,
    input  logic [N-1:0]           wr_data,
`endif
    output logic [N-1:0]           q,
    output logic                   vld
);

    typedef struct packed {
        logic [N-1:0] data;
        logic         vld;
    } port_result_t;

    port_result_t rd_d;
    port_result_t rd_q;

    always_comb begin
        rd_d.data = mem[rd_addr];
        rd_d.vld  = flags[rd_addr];
`ifdef REG_SET_BYPASS_EN
        // Write-first: an effective write to the same entry wins.
        if (wen && (rd_addr == wr_addr)) begin
            rd_d.data = wr_data;
            rd_d.vld  = 1'b1;
        end
`endif
        if (clr) begin
            rd_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign q   = rd_q.data;
    assign vld = rd_q.vld;

endmodule

`default_nettype wire

// File: rtl/reg_set_2r1w.sv
// ============================================================================
// Module : reg_set_2r1w
// Brief  : 2**w x N register set, one write port, two registered read ports,
//          per-entry written flags, synchronous clear. Define REG_SET_BYPASS_EN
//          for write-first forwarding; default build is read-first.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_set_2r1w
    import reg_set_pkg::*;
#(
    parameter int unsigned N = RS_N_DEFAULT,
    parameter int unsigned w = RS_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wen,
    input  logic [w-1:0] Wr_addr,
    input  logic [N-1:0] d,
    input  logic         clr,
    input  logic [w-1:0] read_addr0,
    input  logic [w-1:0] read_addr1,
    output logic [N-1:0] q0,
    output logic [N-1:0] q1,
    output logic         q0_vld,
    output logic         q1_vld
);

    localparam int unsigned DEPTH = rs_depth(w);

    logic [N-1:0]     mem_q [DEPTH];
    logic [N-1:0]     mem_d [DEPTH];
    logic [DEPTH-1:0] flag_q;
    logic [DEPTH-1:0] flag_d;

    // Clear discards a concurrent write.
    always_comb begin
        mem_d  = mem_q;
        flag_d = flag_q;
        if (clr) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_d[i] = '0;
            end
            flag_d = '0;
        end else if (wen) begin
            mem_d[Wr_addr]  = d;
            flag_d[Wr_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            flag_q <= '0;
        end else begin
            mem_q  <= mem_d;
            flag_q <= flag_d;
        end
    end

    // Ports see pre-write storage; forwarding, if built, happens inside.
    reg_set_rd_port #(.N(N), .w(w)) u_rd_port0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .rd_addr (read_addr0),
        .mem     (mem_q),
        .flags   (flag_q),
`ifdef REG_SET_BYPASS_EN
        .wen     (wen),
        .wr_addr (Wr_addr),
        .wr_data (d),
`endif
        .q       (q0),
        .vld     (q0_vld)
    );

    reg_set_rd_port #(.N(N), .w(w)) u_rd_port1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .rd_addr (read_addr1),
        .mem     (mem_q),
        .flags   (flag_q),
`ifdef REG_SET_BYPASS_EN
        .wen     (wen),
        .wr_addr (Wr_addr),
        .wr_data (d),
`endif
        .q       (q1),
        .vld     (q1_vld)
    );

endmodule

`default_nettype wire
